mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have the parameter ADDR_W, default 8: memory address width.
REQ-002 The block SHALL have the parameter DATA_W, default 8: memory data width.
REQ-003 The block SHALL have the port clk  input  1  single system clock, all logic on rising edge.
REQ-004 The block SHALL have the port rst  input  1  reset, synchronous, active-low.
REQ-005 The block SHALL have the ports cpu_req/ldr_req  input  1 each  request from CPU sequencer / program loader.
REQ-006 The block SHALL have the ports cpu_we/ldr_we  input  1 each  1 = write, 0 = read.
REQ-007 The block SHALL have the ports cpu_addr/ldr_addr  input  ADDR_W each  access address.
REQ-008 The block SHALL have the ports cpu_wdata/ldr_wdata  input  DATA_W each  write data.
REQ-009 The block SHALL have the ports cpu_gnt/ldr_gnt  output  1 each  requester owns memory.
REQ-010 The block SHALL have the ports cpu_done/ldr_done  output  1 each  one-cycle completion pulse.
REQ-011 The block SHALL have the port rdata  output  DATA_W  shared read data, valid only while a done is high.
REQ-012 The block SHALL have the port cpu_stall  output  1  freezes the CPU step counter.
REQ-013 The block SHALL have the ports mem_en, mem_we  output  1 each  RAM enable / write strobe.
REQ-014 The block SHALL have the ports mem_addr, mem_wdata  output  ADDR_W, DATA_W  RAM address / write data.
REQ-015 The block SHALL have the port mem_rdata  input  DATA_W  synchronous RAM read data, one-cycle latency.

Function
REQ-016 The FSM SHALL have the states IDLE, ACCESS and DONE, with the transitions IDLE->ACCESS when any req=1, ACCESS->DONE always, and DONE->IDLE always.
REQ-017 In IDLE, the block SHALL register the winner; if only one req=1, that requester wins; if both, the requester not served last wins (round-robin).
REQ-018 After reset, the block SHALL treat LDR as last served, so the first tie goes to CPU.
REQ-019 In ACCESS, the block SHALL drive the winner's gnt=1, mem_en=1, mem_we=winner we, mem_addr=winner addr and mem_wdata=winner wdata.
REQ-020 In DONE, the block SHALL hold the winner's gnt=1 with mem_en=0, pulse the winner's done=1, set rdata=mem_rdata and update the last-served pointer.
REQ-021 Latency: for a req first seen in IDLE at cycle N, the block SHALL assert ACCESS at N+1 and done at N+2; throughput is one transaction per 3 cycles.
REQ-022 Requesters SHALL hold req/we/addr/wdata stable from assertion until done; a req still high in the IDLE following done SHALL be treated as a new transaction.
REQ-023 gnt, done, mem_en and mem_we SHALL be decoded from registered state only, with no combinational path from req.
REQ-024 cpu_stall SHALL equal cpu_req AND NOT cpu_done.
REQ-025 A req asserted during ACCESS/DONE by the non-owner SHALL wait; it is never dropped, and it wins the next IDLE under round-robin.
REQ-026 Outside ACCESS, mem_we SHALL be 0 and mem_addr/mem_wdata are don't-care.

Reset
REQ-027 When rst=0 at a clock edge, the block SHALL enter IDLE with all gnt/done/mem_en/mem_we=0, last-served=LDR and hold_ack=0.
REQ-028 A reset during ACCESS or DONE SHALL abandon the transaction with no done pulse; a write in ACCESS coincident with the reset edge completes at the RAM.

Configuration
REQ-029 When MEM_ARB_HOLD_EN is defined, the block SHALL add the input ldr_hold (1) and the output hold_ack (1).
REQ-030 With MEM_ARB_HOLD_EN, when ldr_hold=1 the block SHALL finish any current transaction, then grant only LDR; hold_ack=1 from the first IDLE cycle with ldr_hold=1 until ldr_hold=0 is sampled; cpu_req waits (cpu_stall=1).
REQ-031 Without MEM_ARB_HOLD_EN, the ldr_hold/hold_ack ports and logic SHALL be absent and the block SHALL use pure round-robin.

Structure
REQ-032 The shared package mem_arb_pkg SHALL hold the FSM state enum and requester indices REQ_CPU=0 and REQ_LDR=1.
REQ-033 The block SHALL use one sub-module, rr_pick: a 2-input round-robin picker (reqs, last-served) -> winner index.

Verification
REQ-034 The bench SHALL cover: CPU read, addr 0x0E, RAM[0x0E]=0x1C -> cpu_gnt at N+1, cpu_done and rdata=0x1C at N+2, cpu_stall=0 at N+3.
REQ-035 The bench SHALL cover: LDR write, addr 0x05, data 0xA7 -> mem_we=1 for exactly one cycle; a following CPU read of 0x05 returns 0xA7.
REQ-036 The bench SHALL cover: both requests held for 4 transactions after reset -> grant order CPU, LDR, CPU, LDR.
REQ-037 The bench SHALL cover: cpu_req raised during an LDR ACCESS -> cpu_stall=1 until CPU done, 3 cycles after the LDR done.
REQ-038 The bench SHALL cover: rst=0 during ACCESS -> no done pulse, IDLE next cycle, and the first tie after reset goes to CPU.
REQ-039 The bench SHALL cover (MEM_ARB_HOLD_EN): ldr_hold=1 plus continuous cpu_req -> hold_ack=1, only LDR granted for 5 writes, CPU resumes after ldr_hold=0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-requester memory arbiter: FSM states and requester indices.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_LDR = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-input round-robin picker: a lone request wins outright, a tie goes to
// the requester that was not served last.
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [1:0] reqs,
    input  logic       last,
    output logic       winner
);

    always_comb begin
        winner = REQ_CPU;
        if (reqs == 2'b11) begin
            winner = ~last;
        end else if (reqs == 2'b10) begin
            winner = REQ_LDR;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port synchronous RAM between the CPU sequencer and the
// program loader. Optional loader hold (ldr_hold/hold_ack) under MEM_ARB_HOLD_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              ldr_req,
    input  logic              cpu_we,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic [DATA_W-1:0] ldr_wdata,
`ifdef MEM_ARB_HOLD_EN
    input  logic              ldr_hold,
    output logic              hold_ack,
`endif
    output logic              cpu_gnt,
    output logic              ldr_gnt,
    output logic              cpu_done,
    output logic              ldr_done,
    output logic [DATA_W-1:0] rdata,
    output logic              cpu_stall,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state;
    logic              owner;
    logic              last;
    logic [1:0]        reqs;
    logic              pick;
    logic              pick_we;
    logic [ADDR_W-1:0] pick_addr;
    logic [DATA_W-1:0] pick_wdata;

`ifdef MEM_ARB_HOLD_EN
    // While the loader holds the memory the CPU request is invisible to the picker.
    assign reqs = {ldr_req, cpu_req & ~ldr_hold};
`else
    assign reqs = {ldr_req, cpu_req};
`endif

    rr_pick u_pick (
        .reqs   (reqs),
        .last   (last),
        .winner (pick)
    );

    assign pick_we    = (pick == REQ_LDR) ? ldr_we    : cpu_we;
    assign pick_addr  = (pick == REQ_LDR) ? ldr_addr  : cpu_addr;
    assign pick_wdata = (pick == REQ_LDR) ? ldr_wdata : cpu_wdata;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            owner    <= REQ_CPU;
            last     <= REQ_LDR;
            cpu_gnt  <= 1'b0;
            ldr_gnt  <= 1'b0;
            cpu_done <= 1'b0;
            ldr_done <= 1'b0;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|reqs) begin
                        state   <= ACCESS;
                        owner   <= pick;
                        cpu_gnt <= (pick == REQ_CPU);
                        ldr_gnt <= (pick == REQ_LDR);
                        mem_en  <= 1'b1;
                        mem_we  <= pick_we;
                    end
                end
                ACCESS: begin
                    state    <= DONE;
                    mem_en   <= 1'b0;
                    mem_we   <= 1'b0;
                    cpu_done <= (owner == REQ_CPU);
                    ldr_done <= (owner == REQ_LDR);
                end
                DONE: begin
                    state    <= IDLE;
                    cpu_gnt  <= 1'b0;
                    ldr_gnt  <= 1'b0;
                    cpu_done <= 1'b0;
                    ldr_done <= 1'b0;
                    last     <= owner;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address/data are captured with the grant so the RAM sees only registered values.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            mem_addr  <= pick_addr;
            mem_wdata <= pick_wdata;
        end
    end

`ifdef MEM_ARB_HOLD_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            hold_ack <= 1'b0;
        end else if (!ldr_hold) begin
            hold_ack <= 1'b0;
        end else if (state == IDLE) begin
            hold_ack <= 1'b1;
        end
    end
`endif

    assign rdata     = mem_rdata;
    assign cpu_stall = cpu_req & ~cpu_done;

endmodule
